stl_rr_pp_arbiter: RTL and testbench

//  N-to-1 round-robin arbiter with packet lock in front of a 2-entry ping-pong buffer.

---
 rtl/stl_rr_pp_arbiter.sv | 167 ++++++++++++++++
 tb/tb_stl_rr_pp_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stl_rr_pp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : stl_rr_pp_arbiter
//  Brief    : N-to-1 round-robin arbiter with packet lock, feeding a
//             2-entry ping-pong output buffer that carries the source index.
//  Revision : 1.0 - initial release
// ============================================================================
module stl_rr_pp_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = 64,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_vld_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_dat_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_rdy_o,
  output logic                      dn_vld_o,
  output logic [DATA_W-1:0]         dn_dat_o,
  output logic                      dn_last_o,
  output logic [ID_W-1:0]           dn_id_o,
  input  logic                      dn_rdy_i,
  output logic                      busy_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_owner;

  // Ping-pong storage: two entries, each with its own valid bit.
  logic [DATA_W-1:0] r_ent_dat [2];
  logic [1:0]        r_ent_last;
  logic [ID_W-1:0]   r_ent_id [2];
  logic [1:0]        r_ent_vld;
  logic              r_wptr;
  logic              r_rptr;

  logic              w_space;
  logic              w_push;
  logic              w_pop;
  logic [ID_W-1:0]   w_win;
  logic              w_win_found;
  logic [ID_W-1:0]   w_gnt_idx;
  logic              w_gnt_vld;
  logic [ID_W-1:0]   w_rr_nxt;
  logic              w_sel_vld;
  logic              w_sel_last;
  logic [DATA_W-1:0] w_sel_dat;

  // (base + ofs) mod NUM_REQ, with ofs < NUM_REQ
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // Space only depends on the entry under wptr, so a same-cycle pop never frees it.
  assign w_space = ~r_ent_vld[r_wptr];
  assign w_pop   = dn_vld_o & dn_rdy_i;

  // Round-robin search: first valid requester at or after rr_ptr, with wrap.
  always_comb begin
    w_win       = '0;
    w_win_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_win_found && req_vld_i[i] && (ID_W'(i) == wrap_add(r_rr_ptr, k))) begin
          w_win       = ID_W'(i);
          w_win_found = 1'b1;
        end
      end
    end
  end

  // While locked the owner keeps the grant even when it is not valid.
  assign w_gnt_idx = (r_state == ST_LOCKED) ? r_owner : w_win;
  assign w_gnt_vld = (r_state == ST_LOCKED) | w_win_found;
  assign w_rr_nxt  = wrap_add(w_gnt_idx, 1);

  // Route the granted requester's beat and drive its ready.
  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_last = 1'b0;
    w_sel_dat  = '0;
    req_rdy_o  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_gnt_idx) begin
        w_sel_vld    = req_vld_i[i];
        w_sel_last   = req_last_i[i];
        w_sel_dat    = req_dat_i[i*DATA_W +: DATA_W];
        req_rdy_o[i] = w_gnt_vld & w_space;
      end
    end
  end

  assign w_push = w_gnt_vld & w_space & w_sel_vld;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: lock on a non-last beat, release on the last beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_push && !w_sel_last) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_push &&  w_sel_last) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Owner capture at packet start; round-robin advance at packet end.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_owner  <= '0;
    end else if (w_push) begin
      if (w_sel_last)                r_rr_ptr <= w_rr_nxt;
      else if (r_state == ST_IDLE)   r_owner  <= w_gnt_idx;
    end
  end

  // Buffer occupancy and pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ent_vld <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
    end else begin
      if (w_push) begin
        r_ent_vld[r_wptr] <= 1'b1;
        r_wptr            <= ~r_wptr;
      end
      if (w_pop) begin
        r_ent_vld[r_rptr] <= 1'b0;
        r_rptr            <= ~r_rptr;
      end
    end
  end

  // Entry payload capture; payload is meaningless until its valid bit is set.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ent_dat[r_wptr]  <= w_sel_dat;
      r_ent_last[r_wptr] <= w_sel_last;
      r_ent_id[r_wptr]   <= w_gnt_idx;
    end
  end

  assign dn_vld_o  = r_ent_vld[r_rptr];
  assign dn_dat_o  = r_ent_dat[r_rptr];
  assign dn_last_o = r_ent_last[r_rptr];
  assign dn_id_o   = r_ent_id[r_rptr];
  assign busy_o    = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_stl_rr_pp_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stl_rr_pp_arbiter
//  Brief    : Self-checking bench for stl_rr_pp_arbiter against a
//             queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stl_rr_pp_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 64;
  localparam int IDW = 2;

  logic             clk;
  logic             rst_n;
  logic [NR-1:0]    req_vld_i;
  logic [NR*DW-1:0] req_dat_i;
  logic [NR-1:0]    req_last_i;
  logic [NR-1:0]    req_rdy_o;
  logic             dn_vld_o;
  logic [DW-1:0]    dn_dat_o;
  logic             dn_last_o;
  logic [IDW-1:0]   dn_id_o;
  logic             dn_rdy_i;
  logic             busy_o;

  stl_rr_pp_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld_i(req_vld_i), .req_dat_i(req_dat_i), .req_last_i(req_last_i),
    .req_rdy_o(req_rdy_o),
    .dn_vld_o(dn_vld_o), .dn_dat_o(dn_dat_o), .dn_last_o(dn_last_o),
    .dn_id_o(dn_id_o), .dn_rdy_i(dn_rdy_i), .busy_o(busy_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model (abstract: beat queue + lock flag) ----
  typedef struct { logic [DW-1:0] dat; logic last; int id; } beat_t;
  beat_t m_q[$];
  bit    m_locked;
  int    m_owner, m_rr;

  // ---------------- requester stimulus state ----------------
  logic          s_vld  [NR];
  logic [DW-1:0] s_dat  [NR];
  logic          s_last [NR];
  int            rem    [NR];
  int            pend   [NR][$];
  int            seq    [NR];
  int            p_vld;
  int            p_rdy;

  int n_chk, n_pass, n_fail;
  int out_lock;

  // values captured mid-cycle for directed checks
  logic [NR-1:0]  g_dut_acc, g_rdy;
  logic           g_dn_vld, g_busy, g_pop;
  logic [DW-1:0]  g_dn_dat;
  logic [IDW-1:0] g_dn_id;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] exp_rdy();
    logic [NR-1:0] r;
    int w;
    r = '0;
    w = -1;
    if (m_locked) w = m_owner;
    else for (int k = 0; k < NR; k++) if (w < 0 && s_vld[(m_rr+k)%NR]) w = (m_rr+k)%NR;
    if (w >= 0 && m_q.size() < 2) r[w] = 1'b1;
    return r;
  endfunction

  function automatic int oh2id(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic bit all_idle();
    bit r;
    r = (m_q.size() == 0);
    for (int i = 0; i < NR; i++) if (s_vld[i] || rem[i] != 0 || pend[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_vld_i[i]           = s_vld[i];
      req_last_i[i]          = s_last[i];
      req_dat_i[i*DW +: DW]  = s_dat[i];
    end
  endtask

  // Idle requesters present their next beat (with probability p_vld).
  task automatic gen();
    for (int i = 0; i < NR; i++) begin
      if (!s_vld[i]) begin
        if (rem[i] == 0 && pend[i].size() > 0) rem[i] = pend[i].pop_front();
        if (rem[i] > 0 && int'($urandom_range(99)) < p_vld) begin
          s_vld[i]  = 1'b1;
          s_last[i] = (rem[i] == 1);
          s_dat[i]  = {8'(i), 24'(seq[i]), 32'($urandom)};
          seq[i]++;
        end
      end
    end
  endtask

  // One clock: drive at +1, check at the falling edge, update model at rise.
  task automatic cycle();
    logic [NR-1:0] er;
    int            acc;
    logic          pop;
    beat_t         b;
    if (p_rdy >= 0) dn_rdy_i = (int'($urandom_range(99)) < p_rdy);
    drive();
    #4;
    er        = exp_rdy();
    g_rdy     = req_rdy_o;
    g_dut_acc = req_rdy_o & req_vld_i;
    g_dn_vld  = dn_vld_o;
    g_dn_dat  = dn_dat_o;
    g_dn_id   = dn_id_o;
    g_busy    = busy_o;
    chk("rdy",    64'(req_rdy_o), 64'(er));
    chk("onehot", 64'($countones(req_rdy_o) <= 1), 64'(1));
    chk("dn_vld", 64'(dn_vld_o), 64'(m_q.size() > 0));
    chk("busy",   64'(busy_o), 64'(m_locked));
    if (m_q.size() > 0) begin
      chk("dn_dat",  dn_dat_o, m_q[0].dat);
      chk("dn_last", 64'(dn_last_o), 64'(m_q[0].last));
      chk("dn_id",   64'(dn_id_o), 64'(m_q[0].id));
    end
    acc = -1;
    for (int i = 0; i < NR; i++) if (er[i] && s_vld[i]) acc = i;
    pop   = (m_q.size() > 0) && dn_rdy_i;
    g_pop = pop;
    if (pop) begin
      if (out_lock >= 0) chk("contig", 64'(dn_id_o), 64'(out_lock));
      out_lock = dn_last_o ? -1 : int'(dn_id_o);
    end
    @(posedge clk);
    if (!rst_n) begin
      m_q.delete();
      m_locked = 1'b0;
      m_rr     = 0;
      m_owner  = 0;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc >= 0) begin
        b.dat  = s_dat[acc];
        b.last = s_last[acc];
        b.id   = acc;
        m_q.push_back(b);
        if (m_locked) begin
          if (b.last) begin m_locked = 1'b0; m_rr = (m_owner + 1) % NR; end
        end else if (!b.last) begin
          m_locked = 1'b1; m_owner = acc;
        end else begin
          m_rr = (acc + 1) % NR;
        end
        s_vld[acc] = 1'b0;
        rem[acc]--;
      end
    end
    gen();
    #1;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < NR; i++) begin
      s_vld[i] = 1'b0; rem[i] = 0; pend[i].delete();
    end
    rst_n = 1'b0;
    repeat (n) cycle();
    rst_n    = 1'b1;
    out_lock = -1;
  endtask

  initial begin
    int            acc_ids[$], busies[$], out_ids[$];
    int            e_acc[4], e_busy[4];
    int            cnt, prev, id;
    logic [DW-1:0] hold_dat, t1_dat;

    n_chk = 0; n_pass = 0; n_fail = 0; out_lock = -1;
    p_vld = 100; p_rdy = -1;
    m_q.delete(); m_locked = 1'b0; m_owner = 0; m_rr = 0;
    for (int i = 0; i < NR; i++) begin
      s_vld[i] = 1'b0; s_last[i] = 1'b0; s_dat[i] = '0; rem[i] = 0; seq[i] = 0;
    end
    rst_n = 1'b0; dn_rdy_i = 1'b1;
    drive();
    @(posedge clk); #1;

    // ---- 1: reset values, single beat from req0, one-cycle latency ----
    do_reset(2);
    chk("rst_dn_vld", 64'(dn_vld_o), 64'(0));
    chk("rst_busy",   64'(busy_o),   64'(0));
    chk("rst_rdy",    64'(req_rdy_o), 64'(0));
    pend[0].push_back(1);
    gen();
    t1_dat = s_dat[0];
    cycle();
    chk("t1_acc", 64'(g_dut_acc), 64'(4'b0001));
    cycle();
    chk("t1_vld",  64'(g_dn_vld), 64'(1));
    chk("t1_dat",  g_dn_dat, t1_dat);
    chk("t1_id",   64'(g_dn_id), 64'(0));
    repeat (2) cycle();

    // ---- 2: all requesters stream single beats, strict rotation, no gaps ----
    for (int i = 0; i < NR; i++) repeat (10) pend[i].push_back(1);
    gen();
    prev = -1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      id = oh2id(g_dut_acc);
      chk("t2_gap", 64'(id >= 0), 64'(1));
      if (prev >= 0) chk("t2_order", 64'(id), 64'((prev + 1) % NR));
      prev = id;
    end
    repeat (3) cycle();

    // ---- 3: req1 3-beat packet locks out req2 ----
    do_reset(1);
    pend[1].push_back(3);
    pend[2].push_back(1);
    gen();
    for (int c = 0; c < 8; c++) begin
      cycle();
      if (g_dut_acc != '0) begin acc_ids.push_back(oh2id(g_dut_acc)); busies.push_back(int'(g_busy)); end
      if (g_pop) out_ids.push_back(int'(g_dn_id));
    end
    e_acc  = '{1, 1, 1, 2};
    e_busy = '{0, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      chk("t3_acc_id",  64'(i < acc_ids.size() ? acc_ids[i] : -1), 64'(e_acc[i]));
      chk("t3_busy",    64'(i < busies.size()  ? busies[i]  : -1), 64'(e_busy[i]));
      chk("t3_out_id",  64'(i < out_ids.size() ? out_ids[i] : -1), 64'(e_acc[i]));
    end

    // ---- 4: downstream stalled, buffer fills at 2, output held, drains ----
    dn_rdy_i = 1'b0;
    repeat (6) pend[0].push_back(1);
    gen();
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      cycle();
      if (g_dut_acc != '0) cnt++;
      if (c == 1) hold_dat = g_dn_dat;
      if (c > 1)  chk("t4_stable", g_dn_dat, hold_dat);
    end
    chk("t4_acc_cnt", 64'(cnt), 64'(2));
    chk("t4_rdy_low", 64'(g_rdy), 64'(0));
    dn_rdy_i = 1'b1;
    cnt = 0;
    for (int c = 0; c < 14; c++) begin
      cycle();
      if (g_dn_vld) cnt++;
    end
    chk("t4_drained", 64'(cnt), 64'(6));

    // ---- 5: reset mid-packet with the buffer full ----
    dn_rdy_i = 1'b0;
    pend[0].push_back(5);
    gen();
    repeat (4) cycle();
    chk("t5_busy_pre", 64'(g_busy), 64'(1));
    chk("t5_full",     64'(g_rdy),  64'(0));
    do_reset(1);
    chk("t5_dn_vld", 64'(dn_vld_o), 64'(0));
    chk("t5_busy",   64'(busy_o),   64'(0));
    pend[2].push_back(1);
    pend[0].push_back(1);
    gen();
    dn_rdy_i = 1'b1;
    cycle();
    chk("t5_req0_wins", 64'(g_dut_acc), 64'(4'b0001));
    repeat (4) cycle();

    // ---- 6: randomised valid/ready, multi-beat packets ----
    for (int i = 0; i < NR; i++) repeat (8) pend[i].push_back(int'($urandom_range(1, 4)));
    p_vld = 60;
    p_rdy = 70;
    gen();
    for (int c = 0; c < 3000 && !all_idle(); c++) cycle();
    chk("t6_drained", 64'(all_idle()), 64'(1));
    p_rdy = -1;
    repeat (2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
